mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_LAT, 1, fixed memory access latency in cycles, legal range 1..15.
REQ-002 Port: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: i_req  in  1  fetch request from control unit, i.e. IMemRead.
REQ-005 Port: i_addr  in  32  fetch address.
REQ-006 Port: i_rdata  out  32  fetched instruction word.
REQ-007 Port: i_ready  out  1  fetch completion pulse.
REQ-008 Port: d_req  in  1  data load/store request.
REQ-009 Port: d_we  in  1  1 = store, 0 = load.
REQ-010 Port: d_addr  in  32  data address.
REQ-011 Port: d_wdata  in  32  store data.
REQ-012 Port: d_rdata  out  32  load data.
REQ-013 Port: d_ready  out  1  data completion pulse.
REQ-014 Port: m_en / m_we  out  1 each  shared single-port memory enable and write strobe.
REQ-015 Port: m_addr / m_wdata  out  32 each  shared memory address and write data.
REQ-016 Port: m_rdata  in  32  memory read data, valid in the final BUSY cycle.

Function
REQ-017 FSM states: IDLE, BUSY, RESP.
- IDLE -> BUSY when any request is high.
- BUSY -> RESP when the wait counter reaches 0.
- RESP -> IDLE unconditionally.
REQ-018 Grant in IDLE, both requests high, macro off: data side wins.
REQ-019 Grant with a single request high: that requester wins, regardless of the macro.
REQ-020 On grant, register the granted address, we (0 for fetch) and wdata into m_addr/m_we/m_wdata, and load the wait counter with MEM_LAT-1.
REQ-021 During BUSY:
- m_en = 1 and m_we is held.
- m_addr/m_wdata stay stable.
- the counter decrements once per cycle.
REQ-022 m_en = 0 and m_we = 0 in IDLE and RESP.
REQ-023 On the BUSY->RESP edge, capture m_rdata into the granted side's rdata register (loads and fetches only).
REQ-024 On a store, d_rdata holds its previous value.
REQ-025 In RESP, assert exactly one of i_ready/d_ready (the granted side) for one cycle.
REQ-026 Latency: request sampled at edge k -> ready high in cycle k+MEM_LAT+1; throughput of one access per MEM_LAT+2 cycles.
REQ-027 Requesters hold req/addr/we/wdata stable until their ready; the arbiter samples them only at grant.
REQ-028 A request still high during RESP is treated as a new request in the following IDLE.
REQ-029 The non-granted request remains pending and receives no ready until served.
REQ-030 i_rdata/d_rdata hold their last captured value between accesses.

Reset
REQ-031 Reset asserted takes effect immediately, independent of clk:
- state = IDLE, counter = 0.
- m_en = m_we = 0, m_addr = m_wdata = 0.
- i_rdata = d_rdata = 0, i_ready = d_ready = 0.
- last-grant register = fetch.
REQ-032 Reset during BUSY or RESP aborts the access: no ready pulse is issued for it after reset release.
REQ-033 First grant is possible at the first rising edge after reset deasserts.

Configuration
REQ-034 Macro MEM_ARBITER_ROUND_ROBIN_EN defined: a last-grant register records the side served.
REQ-035 With the macro defined and both requests high in IDLE, the side not served last wins.
REQ-036 Macro undefined: the last-grant register is absent and REQ-018 fixed data priority applies.

Structure
REQ-037 Shared package cpu_pkg holds:
- enum arb_state_t {IDLE, BUSY, RESP}.
- enum arb_side_t {SIDE_I, SIDE_D}.
- constant MEM_LAT_DEFAULT = 1.
REQ-038 The wait counter (load, decrement, zero flag, 4 bits) is a sub-module named mem_wait_cnt; all else lives in mem_arbiter.

Verification
REQ-039 MEM_LAT=1, i_req=1, i_addr=0x10, m_rdata=0x00000013: m_en high for 1 cycle with m_addr=0x10; i_ready pulses 2 cycles after sampling; i_rdata=0x00000013.
REQ-040 MEM_LAT=3, d_req=1, d_we=1, d_addr=0x80, d_wdata=0xDEADBEEF: m_we=1 for 3 cycles; d_ready at cycle k+4; d_rdata unchanged.
REQ-041 Both requests high from reset, macro off: data served first, fetch second.
REQ-041a Same stimulus, macro on: fetch served first, then data, alternating while both stay high.
REQ-042 Reset asserted mid-BUSY with MEM_LAT=4: all outputs 0 immediately; no ready pulse after release; a new i_req is granted at the first edge.
REQ-043 Back-to-back: i_req held high across RESP: second fetch m_en rises exactly 2 cycles after the first i_ready (RESP then IDLE bubble).

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the instruction/data memory arbiter.
//   arb_state_t     : arbiter FSM states (IDLE, BUSY, RESP)
//   arb_side_t      : requester identity (SIDE_I = fetch, SIDE_D = data)
//   mem_cmd_t       : payload registered onto the shared memory port
//   MEM_LAT_DEFAULT : default memory access latency in cycles
// Optional feature macro used by the arbiter: MEM_ARBITER_ROUND_ROBIN_EN
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam int unsigned MEM_LAT_DEFAULT = 1;
   localparam int unsigned WORD_W          = 32;
   localparam int unsigned CNT_W           = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      SIDE_I = 1'b0,
      SIDE_D = 1'b1
   } arb_side_t;

   // One access as presented to the shared single-port memory
   typedef struct packed {
      logic              we;
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] wdata;
   } mem_cmd_t;

   // The requester that is not s
   function automatic arb_side_t other_side(input arb_side_t s);
      return (s == SIDE_I) ? SIDE_D : SIDE_I;
   endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// ----------------------------------------------------------------------------
// mem_wait_cnt
// 4-bit down counter that times the BUSY phase of a memory access.
// Ports:
//   clk        : clock
//   reset      : asynchronous active-high reset
//   load_i     : load load_val_i (takes priority over decrement)
//   load_val_i : value to load (MEM_LAT-1)
//   dec_i      : decrement by one while non-zero
//   zero_o     : registered flag, high while the count is zero
// ----------------------------------------------------------------------------
module mem_wait_cnt
   import cpu_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic             zero_q;

   // Count and zero flag update together so zero_o needs no decode after the flop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         zero_q <= 1'b1;
      end else if (load_i) begin
         cnt_q  <= load_val_i;
         zero_q <= (load_val_i == '0);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q  <= cnt_q - CNT_W'(1);
         zero_q <= (cnt_q == CNT_W'(1));
      end
   end

   assign zero_o = zero_q;

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between an instruction-fetch requester and a
// data load/store requester. Each access runs IDLE -> BUSY (MEM_LAT cycles,
// m_en high) -> RESP (one-cycle ready pulse to the granted side) -> IDLE.
// Parameter:
//   MEM_LAT  : fixed memory latency in cycles, legal range 1..15
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   i_req, i_addr                   : fetch request and address
//   i_rdata, i_ready                : fetched word, fetch completion pulse
//   d_req, d_we, d_addr, d_wdata    : data request, store flag, address, data
//   d_rdata, d_ready                : load data, data completion pulse
//   m_en, m_we, m_addr, m_wdata     : shared memory command (registered)
//   m_rdata                         : memory read data, valid in last BUSY cycle
// Configuration macro:
//   MEM_ARBITER_ROUND_ROBIN_EN : defined  -> ties alternate between sides
//                                undefined -> ties go to the data side
// ----------------------------------------------------------------------------
module mem_arbiter
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ready,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   output logic        m_en,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata
);

   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

   arb_state_t  state_q;
   arb_side_t   side_q;
   logic        m_en_q;
   logic        m_we_q;
   logic [31:0] m_addr_q;
   logic [31:0] m_wdata_q;
   logic [31:0] i_rdata_q;
   logic [31:0] d_rdata_q;
   logic        i_ready_q;
   logic        d_ready_q;

   logic        any_req;
   logic        grant_c;
   arb_side_t   tie_side;
   arb_side_t   grant_side;
   mem_cmd_t    grant_cmd;
   logic        cnt_dec;
   logic        cnt_zero;

   assign any_req = i_req | d_req;
   assign grant_c = (state_q == IDLE) && any_req;
   assign cnt_dec = (state_q == BUSY);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   arb_side_t last_grant_q;
   logic      rr_seen_q;

   // Fetch takes the first tie after reset; afterwards the side not served last
   assign tie_side = rr_seen_q ? other_side(last_grant_q) : SIDE_I;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= SIDE_I;
         rr_seen_q    <= 1'b0;
      end else if (grant_c) begin
         last_grant_q <= grant_side;
         rr_seen_q    <= 1'b1;
      end
   end
`else
   assign tie_side = SIDE_D;
`endif

   // Winner of the current IDLE cycle
   always_comb begin
      grant_side = SIDE_I;
      if (i_req && d_req) begin
         grant_side = tie_side;
      end else if (d_req) begin
         grant_side = SIDE_D;
      end
   end

   // Memory command of the winner; fetches never write
   always_comb begin
      grant_cmd = '0;
      if (grant_side == SIDE_D) begin
         grant_cmd.we    = d_we;
         grant_cmd.addr  = d_addr;
         grant_cmd.wdata = d_wdata;
      end else begin
         grant_cmd.we    = 1'b0;
         grant_cmd.addr  = i_addr;
         grant_cmd.wdata = '0;
      end
   end

   mem_wait_cnt u_wait_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (grant_c),
      .load_val_i (LAT_LOAD),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   // Arbiter FSM with registered memory command, read data and ready pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         side_q    <= SIDE_I;
         m_en_q    <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
      end else begin
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  state_q   <= BUSY;
                  side_q    <= grant_side;
                  m_en_q    <= 1'b1;
                  m_we_q    <= grant_cmd.we;
                  m_addr_q  <= grant_cmd.addr;
                  m_wdata_q <= grant_cmd.wdata;
               end
            end
            BUSY: begin
               // m_rdata is valid in this final BUSY cycle
               if (cnt_zero) begin
                  state_q <= RESP;
                  m_en_q  <= 1'b0;
                  m_we_q  <= 1'b0;
                  if (side_q == SIDE_I) begin
                     i_rdata_q <= m_rdata;
                     i_ready_q <= 1'b1;
                  end else begin
                     d_ready_q <= 1'b1;
                     if (!m_we_q) begin
                        d_rdata_q <= m_rdata;
                     end
                  end
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign i_rdata = i_rdata_q;
   assign i_ready = i_ready_q;
   assign d_rdata = d_rdata_q;
   assign d_ready = d_ready_q;
   assign m_en    = m_en_q;
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench: a MEM_LAT=3 arbiter checked every cycle against a
// timestamp-based transaction model, plus a MEM_LAT=1 instance driven with
// directed fetch sequences and literal expectations.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int LAT = 3;

   logic        clk;
   logic        reset;

   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
   logic        i_ready, d_ready, m_en, m_we;

   logic        l1_i_req, l1_d_req, l1_d_we;
   logic [31:0] l1_i_addr, l1_d_addr, l1_d_wdata;
   logic [31:0] l1_i_rdata, l1_d_rdata, l1_m_addr, l1_m_wdata, l1_m_rdata;
   logic        l1_i_ready, l1_d_ready, l1_m_en, l1_m_we;

   logic [31:0] noise;

   int errors = 0;
   int checks = 0;

   // Memory contents as a pure function of the address
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Read data is only meaningful while m_en is high; garbage otherwise
   assign m_rdata    = m_en ? mem_f(m_addr) : noise;
   assign l1_m_rdata = l1_m_en ? ((l1_m_addr == 32'h10) ? 32'h0000_0013 : mem_f(l1_m_addr)) : noise;

   mem_arbiter #(.MEM_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   mem_arbiter #(.MEM_LAT(1)) u_lat1 (
      .clk(clk), .reset(reset),
      .i_req(l1_i_req), .i_addr(l1_i_addr), .i_rdata(l1_i_rdata), .i_ready(l1_i_ready),
      .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
      .d_rdata(l1_d_rdata), .d_ready(l1_d_ready),
      .m_en(l1_m_en), .m_we(l1_m_we), .m_addr(l1_m_addr), .m_wdata(l1_m_wdata),
      .m_rdata(l1_m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- transaction model ----------------
   // An access granted at edge g has m_en high for edges g..g+LAT-1, its ready
   // after edge g+LAT, and the next grant can happen no earlier than g+LAT+2.
   int          mdl_edge;
   int          mdl_g_edge;
   bit          mdl_active;
   bit          mdl_gd;
   bit          mdl_gwe;
   logic [31:0] mdl_gaddr, mdl_gwdata, mdl_irdata, mdl_drdata;
   bit          mdl_last_d, mdl_served;
   logic        mdl_win_d;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   assign mdl_win_d = d_req && (!i_req || (mdl_served && !mdl_last_d));
`else
   assign mdl_win_d = d_req;
`endif

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mdl_edge   <= 0;
         mdl_g_edge <= 0;
         mdl_active <= 1'b0;
         mdl_gd     <= 1'b0;
         mdl_gwe    <= 1'b0;
         mdl_gaddr  <= '0;
         mdl_gwdata <= '0;
         mdl_irdata <= '0;
         mdl_drdata <= '0;
         mdl_last_d <= 1'b0;
         mdl_served <= 1'b0;
      end else begin
         mdl_edge <= mdl_edge + 1;
         if (mdl_active) begin
            if (mdl_edge + 1 - mdl_g_edge == LAT) begin
               if (!mdl_gd) mdl_irdata <= mem_f(mdl_gaddr);
               else if (!mdl_gwe) mdl_drdata <= mem_f(mdl_gaddr);
            end
            if (mdl_edge + 1 - mdl_g_edge == LAT + 1) mdl_active <= 1'b0;
         end else if (i_req || d_req) begin
            mdl_active <= 1'b1;
            mdl_g_edge <= mdl_edge + 1;
            mdl_gd     <= mdl_win_d;
            mdl_gwe    <= mdl_win_d ? d_we : 1'b0;
            mdl_gaddr  <= mdl_win_d ? d_addr : i_addr;
            mdl_gwdata <= mdl_win_d ? d_wdata : 32'h0;
            mdl_last_d <= mdl_win_d;
            mdl_served <= 1'b1;
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic compare_main();
      bit en_e, rdy_i, rdy_d;
      int age;
      en_e = 1'b0; rdy_i = 1'b0; rdy_d = 1'b0;
      if (mdl_active) begin
         age  = mdl_edge - mdl_g_edge;
         en_e = (age < LAT);
         if (age == LAT) begin
            rdy_i = !mdl_gd;
            rdy_d = mdl_gd;
         end
      end
      chk("m_en",    32'(m_en),    32'(en_e));
      chk("m_we",    32'(m_we),    32'(en_e && mdl_gwe));
      chk("m_addr",  m_addr,       mdl_gaddr);
      chk("m_wdata", m_wdata,      mdl_gwdata);
      chk("i_ready", 32'(i_ready), 32'(rdy_i));
      chk("d_ready", 32'(d_ready), 32'(rdy_d));
      chk("i_rdata", i_rdata,      mdl_irdata);
      chk("d_rdata", d_rdata,      mdl_drdata);
   endtask

   task automatic tick();
      @(negedge clk);
      if (!reset) compare_main();
   endtask

   task automatic chk_main_zero(input string tag);
      chk({tag, "_m_en"},    32'(m_en),    32'h0);
      chk({tag, "_m_we"},    32'(m_we),    32'h0);
      chk({tag, "_m_addr"},  m_addr,       32'h0);
      chk({tag, "_m_wdata"}, m_wdata,      32'h0);
      chk({tag, "_i_rdata"}, i_rdata,      32'h0);
      chk({tag, "_d_rdata"}, d_rdata,      32'h0);
      chk({tag, "_i_ready"}, 32'(i_ready), 32'h0);
      chk({tag, "_d_ready"}, 32'(d_ready), 32'h0);
   endtask

   // Wait for the given side's ready, counting ticks; expiry is a failure
   task automatic wait_ready(input bit data_side, input int budget, output int n);
      n = 0;
      for (int t = 1; t <= budget; t++) begin
         tick();
         if ((data_side && d_ready) || (!data_side && i_ready)) begin
            n = t;
            break;
         end
      end
      chk(data_side ? "d_ready_timeout" : "i_ready_timeout", 32'(n != 0), 32'h1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int n, we_cnt, rdy_at, nord, i_wait, d_wait;
      bit ord0_d, ord1_d;
      logic [31:0] first_addr;

      reset = 1'b1; noise = 32'hA5A5_5A5A;
      l1_i_req = 0; l1_i_addr = 0; l1_d_req = 0; l1_d_we = 0; l1_d_addr = 0; l1_d_wdata = 0;
      // Both sides requesting from reset
      i_req = 1; i_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200; d_wdata = 32'h1111_2222;
      #1;
      chk_main_zero("rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_main_zero("rst_held");
      reset = 1'b0;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      first_addr = 32'h100;
`else
      first_addr = 32'h200;
`endif
      tick();
      chk("tie_first_addr", m_addr, first_addr);
      chk("tie_first_en", 32'(m_en), 32'h1);

      nord = 0; ord0_d = 0; ord1_d = 0;
      for (int t = 0; t < 2 * (LAT + 2) + 4; t++) begin
         tick();
         if (i_ready || d_ready) begin
            if (nord == 0) ord0_d = d_ready; else ord1_d = d_ready;
            nord++;
            if (d_ready) d_req = 0;
            if (i_ready) i_req = 0;
         end
      end
      chk("tie_count", 32'(nord), 32'd2);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      chk("tie_order0_is_data", 32'(ord0_d), 32'h0);
      chk("tie_order1_is_data", 32'(ord1_d), 32'h1);
`else
      chk("tie_order0_is_data", 32'(ord0_d), 32'h1);
      chk("tie_order1_is_data", 32'(ord1_d), 32'h0);
`endif

      // Load then store at LAT=3; store leaves d_rdata alone
      d_req = 1; d_we = 0; d_addr = 32'h40; d_wdata = 32'h5555_0000;
      wait_ready(1'b1, 10, n);
      d_req = 0;
      chk("load_rdata", d_rdata, mem_f(32'h40));
      tick();
      d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF;
      we_cnt = 0; rdy_at = 0;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (t == 1) begin
            chk("store_m_addr",  m_addr,  32'h80);
            chk("store_m_wdata", m_wdata, 32'hDEAD_BEEF);
         end
         if (m_we) we_cnt++;
         if (d_ready) begin
            rdy_at = t;
            break;
         end
      end
      d_req = 0; d_we = 0;
      chk("store_we_cycles", 32'(we_cnt), 32'd3);
      chk("store_ready_at", 32'(rdy_at), 32'd4);
      chk("store_keeps_rdata", d_rdata, mem_f(32'h40));

      // Reset in the middle of BUSY
      tick();
      i_req = 1; i_addr = 32'h300;
      tick();
      tick();
      #2 reset = 1'b1;
      #1 chk_main_zero("rst_busy");
      i_req = 0;
      @(posedge clk);
      @(negedge clk);
      i_req = 1; i_addr = 32'h340; reset = 1'b0;
      tick();
      chk("post_rst_m_en",   32'(m_en),   32'h1);
      chk("post_rst_m_addr", m_addr,      32'h340);
      wait_ready(1'b0, 10, n);
      chk("post_rst_ready_at", 32'(n), 32'(LAT));
      i_req = 0;
      chk("post_rst_i_rdata", i_rdata, mem_f(32'h340));

      // MEM_LAT=1 instance: single fetch, then back-to-back with i_req held
      l1_i_req = 1; l1_i_addr = 32'h10;
      tick();
      chk("l1_m_en_1",   32'(l1_m_en),    32'h1);
      chk("l1_m_addr_1", l1_m_addr,       32'h10);
      chk("l1_m_we_1",   32'(l1_m_we),    32'h0);
      chk("l1_ready_1",  32'(l1_i_ready), 32'h0);
      tick();
      chk("l1_m_en_2",   32'(l1_m_en),    32'h0);
      chk("l1_ready_2",  32'(l1_i_ready), 32'h1);
      chk("l1_rdata_2",  l1_i_rdata,      32'h0000_0013);
      chk("l1_dready_2", 32'(l1_d_ready), 32'h0);
      l1_i_addr = 32'h14;
      tick();
      chk("l1_ready_3",  32'(l1_i_ready), 32'h0);
      chk("l1_m_en_3",   32'(l1_m_en),    32'h0);
      tick();
      chk("l1_m_en_4",   32'(l1_m_en),    32'h1);
      chk("l1_m_addr_4", l1_m_addr,       32'h14);
      tick();
      chk("l1_ready_5",  32'(l1_i_ready), 32'h1);
      chk("l1_rdata_5",  l1_i_rdata,      mem_f(32'h14));
      l1_i_req = 0;
      tick();
      chk("l1_m_en_6",   32'(l1_m_en),    32'h0);
      chk("l1_ready_6",  32'(l1_i_ready), 32'h0);
      chk("l1_d_rdata",  l1_d_rdata,      32'h0);
      chk("l1_m_wdata",  l1_m_wdata,      32'h0);

      // Randomised traffic against the model
      i_wait = 0; d_wait = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         noise = $urandom;
         if (i_req) begin
            if (i_ready) begin
               chk("fetch_wait_bound", 32'(i_wait <= 200), 32'h1);
               i_wait = 0;
               if ($urandom_range(1, 0) == 1) i_addr = $urandom;
               else i_req = 0;
            end else begin
               i_wait++;
            end
         end else if ($urandom_range(9, 0) < 3) begin
            i_req = 1; i_addr = $urandom;
         end
         if (d_req) begin
            if (d_ready) begin
               chk("data_wait_bound", 32'(d_wait <= 200), 32'h1);
               d_wait = 0;
               if ($urandom_range(1, 0) == 1) begin
                  d_we = 1'($urandom_range(1, 0)); d_addr = $urandom; d_wdata = $urandom;
               end else begin
                  d_req = 0;
               end
            end else begin
               d_wait++;
            end
         end else if ($urandom_range(9, 0) < 3) begin
            d_req = 1; d_we = 1'($urandom_range(1, 0)); d_addr = $urandom; d_wdata = $urandom;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
